irq_pending_arbiter: RTL and testbench
======================================

# irq_pending_arbiter

Upstream stage of the interrupt-routed data selector. It captures rising-edge interrupt requests into sticky pending bits and applies a mask. It grants one request at a time as a strictly one-hot `interrupt[3:0]` vector, which drives the selector's `interrupt` input, and holds the grant until acknowledged or timed out. It guarantees the selector never sees a multi-hot vector such as 4'b1111.

## Interface
- `TIMEOUT`, 16, number of cycles a grant is held without `irq_ack` before it is withdrawn; legal range 2..255.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `irq_req`  in  4  request lines (level); a 0->1 transition on bit i raises pending[i].
- `irq_mask`  in  4  1 = bit masked: stays pending but is never selected for grant.
- `irq_ack`  in  1  downstream acknowledge of the current grant; sampled only in GRANT.
- `interrupt`  out  4  one-hot grant vector, or 4'b0000 when no grant.
- `irq_valid`  out  1  high exactly when `interrupt` != 0.
- `pending`  out  4  current sticky pending register.
- `timeout`  out  1  one-cycle pulse when a grant is withdrawn for lack of ack.

## Operation
- Edge detect: `req_q` registers `irq_req`; `rise = irq_req & ~req_q`. A level already high when reset releases counts as a rise on the first post-reset edge.
- Pending update each edge: `pending_next = (pending & ~clr) | rise`, where `clr` is the one-hot bit being acknowledged this edge. Set wins over clear on the same bit.
- Eligible: `elig = pending & ~irq_mask`. Fixed priority: bit 3 highest, bit 0 lowest.
- FSM has two states, IDLE and GRANT.
  - IDLE: `interrupt` = 0. If `elig` != 0 at the edge, load `interrupt` with the highest-priority eligible bit, clear the hold counter, and go to GRANT. Otherwise stay.
  - GRANT: `interrupt` is frozen. Mask or pending changes on other bits do not alter it.
    - If `irq_ack` = 1 at the edge: clear that pending bit (subject to set-wins), drive `interrupt` to 0, and go to IDLE.
    - Else if hold counter == TIMEOUT-1: drive `interrupt` to 0, pulse `timeout` for one cycle, keep the pending bit, and go to IDLE.
    - Else increment the hold counter.
  - `irq_ack` and timeout on the same edge: ack wins, no `timeout` pulse.
- Every return to IDLE yields at least one cycle of `interrupt` = 0, so two grants are never back-to-back without a gap.
- `irq_ack` in IDLE is ignored.
- Masking a granted bit mid-grant does not revoke the grant. After it completes or times out, that bit is not re-granted while masked.
- Hold counter width is 8 bits; it never wraps because it is compared against TIMEOUT-1 <= 254.

## Timing
- Reset (sync, `rst` = 1 at an edge): `req_q`, `pending`, `interrupt`, hold counter, and `timeout` all become 0; `irq_valid` = 0; state is IDLE. `rst` during GRANT drops the grant with no `timeout` pulse.
- Request latency: rise sampled at edge k sets `pending` after edge k. The grant appears after edge k+1 if the FSM is in IDLE.
- Ack latency: ack sampled at edge m causes `interrupt` = 0 and the pending bit clear after edge m. The next grant can appear no earlier than after edge m+1.
- Timeout: the grant is visible for exactly TIMEOUT cycles with no ack. `timeout` is high for the one cycle after the withdrawing edge.
- All outputs are registered; `irq_valid` is the OR of the registered `interrupt`.

## Test plan
- Reset then single request: `irq_req` = 4'b0001 held → `pending` = 4'b0001 one cycle later, then `interrupt` = 4'b0001 and `irq_valid` = 1 one cycle after that. Ack → `interrupt` = 0 and `pending` = 0.
- Simultaneous requests: `irq_req` 0 -> 4'b1111 in one cycle → grants 1000, 0100, 0010, 0001 in order, each acknowledged, each separated by at least one all-zero cycle. `interrupt` is never multi-hot.
- Mask: `irq_mask` = 4'b1000, requests 4'b1010 → 4'b0010 is granted first. After its ack, `interrupt` stays 0 and `pending` = 4'b1000 until the mask clears, then 4'b1000 is granted.
- Timeout with TIMEOUT = 16 and no ack: `interrupt` = 4'b0100 for exactly 16 cycles, then 0 with a one-cycle `timeout` pulse. `pending[2]` stays 1 and the bit is re-granted after the gap.
- Set-wins: new rise on bit 1 on the same edge as ack of bit 1 → `pending[1]` remains 1 and bit 1 is re-granted. Ack plus timeout on the same edge → no `timeout` pulse.
- Mid-grant reset: `rst` = 1 during GRANT → next cycle all outputs 0, `pending` = 0, and `timeout` = 0.

Source files
------------

// File: rtl/irq_pending_arbiter.sv
// Interrupt pending/grant stage: captures rising-edge requests into sticky pending
// bits and grants one unmasked request at a time as a strictly one-hot vector.
module irq_pending_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] irq_req,
    input  logic [3:0] irq_mask,
    input  logic       irq_ack,
    output logic [3:0] interrupt,
    output logic       irq_valid,
    output logic [3:0] pending,
    output logic       timeout
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    logic [0:0] state_q;
    logic [3:0] req_q;
    logic [3:0] pending_q;
    logic [3:0] grant_q;
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] elig;
    logic [3:0] pending_next;

    function automatic logic [3:0] pick_highest(input logic [3:0] v);
        logic [3:0] p;
        p = 4'b0000;
        if (v[3])      p = 4'b1000;
        else if (v[2]) p = 4'b0100;
        else if (v[1]) p = 4'b0010;
        else if (v[0]) p = 4'b0001;
        return p;
    endfunction

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        rise         = irq_req & ~req_q;
        clr          = 4'b0000;
        if (state_q == ST_GRANT && irq_ack)
            clr = grant_q;
        // A fresh rise on the acknowledged bit survives the clear.
        pending_next = (pending_q & ~clr) | rise;
        elig         = pending_q & ~irq_mask;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            req_q      <= 4'b0000;
            pending_q  <= 4'b0000;
            grant_q    <= 4'b0000;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            req_q     <= irq_req;
            pending_q <= pending_next;
            timeout_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (elig != 4'b0000) begin
                    grant_q    <= pick_highest(elig);
                    hold_cnt_q <= 8'd0;
                    state_q    <= ST_GRANT;
                end
            end else begin
                // Ack takes precedence over an expiring hold counter.
                if (irq_ack) begin
                    grant_q <= 4'b0000;
                    state_q <= ST_IDLE;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    grant_q   <= 4'b0000;
                    timeout_q <= 1'b1;
                    state_q   <= ST_IDLE;
                end else begin
                    hold_cnt_q <= hold_cnt_q + 8'd1;
                end
            end
        end
    end

    assign interrupt = grant_q;
    assign irq_valid = |grant_q;
    assign pending   = pending_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Self-checking bench for irq_pending_arbiter: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural model every cycle.
module tb_irq_pending_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq_req;
    logic [3:0] irq_mask;
    logic       irq_ack;
    logic [3:0] interrupt;
    logic       irq_valid;
    logic [3:0] pending;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: granted request as an index (-1 = none), cycles held,
    // pending bits, previous request levels, timeout pulse.
    int         m_grant;
    int         m_held;
    logic [3:0] m_pend;
    logic [3:0] m_prev;
    logic       m_to;

    irq_pending_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_req   (irq_req),
        .irq_mask  (irq_mask),
        .irq_ack   (irq_ack),
        .interrupt (interrupt),
        .irq_valid (irq_valid),
        .pending   (pending),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_interrupt();
        logic [3:0] v;
        v = 4'b0000;
        if (m_grant >= 0) v[m_grant] = 1'b1;
        return v;
    endfunction

    // Applies one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0] new_pend;
        int         found;
        if (rst) begin
            m_grant = -1; m_held = 0; m_pend = 4'b0000; m_prev = 4'b0000; m_to = 1'b0;
            return;
        end
        new_pend = m_pend;
        m_to     = 1'b0;
        if (m_grant >= 0) begin
            if (irq_ack) begin
                new_pend[m_grant] = 1'b0;
                m_grant = -1;
            end else if (m_held == TIMEOUT - 1) begin
                m_grant = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end else begin
            found = -1;
            for (int i = 3; i >= 0; i--)
                if (found < 0 && m_pend[i] && !irq_mask[i]) found = i;
            if (found >= 0) begin
                m_grant = found;
                m_held  = 0;
            end
        end
        for (int i = 0; i < 4; i++)
            if (irq_req[i] && !m_prev[i]) new_pend[i] = 1'b1;
        m_pend = new_pend;
        m_prev = irq_req;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("interrupt", interrupt, model_interrupt());
        check("irq_valid", {3'b000, irq_valid}, {3'b000, m_grant >= 0});
        check("pending",   pending, m_pend);
        check("timeout",   {3'b000, timeout}, {3'b000, m_to});
        check("onehot0",   {3'b000, $onehot0(interrupt)}, 4'b0001);
    endtask

    initial begin
        int cnt;
        m_grant = -1; m_held = 0; m_pend = 4'b0000; m_prev = 4'b0000; m_to = 1'b0;
        rst = 1'b1; irq_req = 4'b0000; irq_mask = 4'b0000; irq_ack = 1'b0;
        step(); step();
        check("reset_interrupt", interrupt, 4'b0000);
        check("reset_pending", pending, 4'b0000);

        // Single request, held level.
        rst = 1'b0; irq_req = 4'b0001;
        step();
        check("single_pending", pending, 4'b0001);
        check("single_no_grant_yet", interrupt, 4'b0000);
        step();
        check("single_grant", interrupt, 4'b0001);
        check("single_valid", {3'b000, irq_valid}, 4'b0001);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("single_ack_int", interrupt, 4'b0000);
        check("single_ack_pend", pending, 4'b0000);
        irq_req = 4'b0000;
        step();

        // All four at once: strict priority order with gaps.
        irq_req = 4'b1111;
        step();
        for (int g = 3; g >= 0; g--) begin
            logic [3:0] want;
            want = 4'b0000;
            want[g] = 1'b1;
            for (int k = 0; k < 5 && interrupt == 4'b0000; k++) step();
            check("prio_grant", interrupt, want);
            irq_ack = 1'b1;
            step();
            irq_ack = 1'b0;
            check("prio_gap", interrupt, 4'b0000);
        end
        irq_req = 4'b0000;
        step();

        // Masked bit stays pending until unmasked.
        irq_mask = 4'b1000; irq_req = 4'b1010;
        step(); step();
        check("mask_first", interrupt, 4'b0010);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        repeat (4) step();
        check("mask_hold_int", interrupt, 4'b0000);
        check("mask_hold_pend", pending, 4'b1000);
        irq_mask = 4'b0000;
        step();
        check("mask_released", interrupt, 4'b1000);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0; irq_req = 4'b0000;
        step();

        // Timeout without ack.
        irq_req = 4'b0100;
        step(); step();
        cnt = 0;
        while (interrupt == 4'b0100 && cnt < 40) begin
            cnt++;
            step();
        end
        check("timeout_len", 4'(cnt), 4'(TIMEOUT));
        check("timeout_pulse", {3'b000, timeout}, 4'b0001);
        check("timeout_keep_pend", pending, 4'b0100);
        step();
        check("timeout_regrant", interrupt, 4'b0100);
        check("timeout_pulse_end", {3'b000, timeout}, 4'b0000);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0; irq_req = 4'b0000;
        step();

        // Set wins over clear on the acknowledged bit.
        irq_req = 4'b0010;
        step(); step();
        irq_req = 4'b0000;
        step();
        irq_req = 4'b0010; irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("setwins_pend", pending, 4'b0010);
        check("setwins_gap", interrupt, 4'b0000);
        step();
        check("setwins_regrant", interrupt, 4'b0010);
        // Ack on the same edge the hold counter expires.
        repeat (TIMEOUT - 1) step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0; irq_req = 4'b0000;
        check("ack_vs_timeout_pulse", {3'b000, timeout}, 4'b0000);
        check("ack_vs_timeout_int", interrupt, 4'b0000);
        step();

        // Reset in the middle of a grant.
        irq_req = 4'b0001;
        step(); step();
        check("midrst_granted", interrupt, 4'b0001);
        rst = 1'b1;
        step();
        check("midrst_int", interrupt, 4'b0000);
        check("midrst_pend", pending, 4'b0000);
        check("midrst_timeout", {3'b000, timeout}, 4'b0000);
        rst = 1'b0; irq_req = 4'b0000;
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            irq_req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) irq_mask = 4'($urandom);
            irq_ack = ($urandom_range(0, 2) == 0);
            rst     = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
